mpe_gemv_tile_engine: RTL and testbench

//  Parametrised successor MPE core: computes y = sat((W*x) >>> shift) for a K-length activation vector x
//  and cfg_groups row-groups of NUM_LANES weight rows, with NUM_LANES MAC lanes working in parallel.
//  x is loaded once into an internal buffer and reused for every group. The block sits between the

---
 rtl/mpe_gemv_tile_engine.sv | 114 +++++++++++
 tb/tb_mpe_gemv_tile_engine.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mpe_gemv_tile_engine.sv
// mpe_gemv_tile_engine: y = sat((W*x) >>> shift) over NUM_LANES parallel MAC lanes, x buffered once and reused per row-group
module mpe_gemv_tile_engine #(
  parameter int NUM_LANES   = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ACCUM_WIDTH = 32,
  parameter int MAX_K       = 256,
  parameter int GROUP_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [$clog2(MAX_K+1)-1:0]      cfg_k,
  input  logic [GROUP_WIDTH-1:0]          cfg_groups,
  input  logic [$clog2(ACCUM_WIDTH)-1:0]  cfg_shift,
  input  logic                            x_valid,
  output logic                            x_ready,
  input  logic [DATA_WIDTH-1:0]           x_data,
  input  logic                            w_valid,
  output logic                            w_ready,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] w_data,
  output logic                            y_valid,
  input  logic                            y_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0] y_data,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);
  localparam int KW = $clog2(MAX_K+1);
  localparam int SW = $clog2(ACCUM_WIDTH);
  localparam int AW = (MAX_K > 1) ? $clog2(MAX_K) : 1;
  localparam int DW = DATA_WIDTH;
  localparam logic signed [ACCUM_WIDTH-1:0] YMAX = ACCUM_WIDTH'((1 << (DW-1)) - 1);
  localparam logic signed [ACCUM_WIDTH-1:0] YMIN = -YMAX - 1;

  typedef enum logic [2:0] {IDLE, LOAD_X, COMPUTE, OUTPUT, DONE} state_t;
  state_t state, state_nx;

  logic [KW-1:0]                 k_cfg, k_idx;
  logic [GROUP_WIDTH-1:0]        g_cfg, grp;
  logic [SW-1:0]                 sh_cfg;
  logic signed [DW-1:0]          x_buf [MAX_K];
  logic signed [DW-1:0]          x_cur;
  logic signed [ACCUM_WIDTH-1:0] acc  [NUM_LANES];
  logic signed [ACCUM_WIDTH-1:0] prod [NUM_LANES];
  logic cfg_ok, x_hs, w_hs, y_hs, k_last, g_last;

  assign cfg_ok  = cfg_k != '0 && cfg_k <= KW'(MAX_K) && cfg_groups != '0;
  assign x_ready = state == LOAD_X;
  assign w_ready = state == COMPUTE;
  assign y_valid = state == OUTPUT;
  assign busy    = state != IDLE;
  assign done    = state == DONE;
  assign x_hs    = x_valid && x_ready;
  assign w_hs    = w_valid && w_ready;
  assign y_hs    = y_valid && y_ready;
  assign k_last  = k_idx == k_cfg - 1'b1;
  assign g_last  = grp == g_cfg - 1'b1;
  assign x_cur   = x_buf[k_idx[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (start && cfg_ok) ? LOAD_X : IDLE;
      LOAD_X:  state_nx = (x_hs && k_last) ? COMPUTE : LOAD_X;
      COMPUTE: state_nx = (w_hs && k_last) ? OUTPUT : COMPUTE;
      OUTPUT:  state_nx = y_hs ? (g_last ? DONE : COMPUTE) : OUTPUT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (x_hs) x_buf[k_idx[AW-1:0]] <= x_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_cfg  <= '0;
      g_cfg  <= '0;
      sh_cfg <= '0;
      k_idx  <= '0;
      grp    <= '0;
      err    <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) acc[l] <= '0;
    end else begin
      err <= state == IDLE && start && !cfg_ok;
      if (state == IDLE && start && cfg_ok) begin
        k_cfg  <= cfg_k;
        g_cfg  <= cfg_groups;
        sh_cfg <= cfg_shift;
        k_idx  <= '0;
        grp    <= '0;
      end
      if (x_hs || w_hs) k_idx <= k_last ? '0 : k_idx + 1'b1;
      if (y_hs) grp <= grp + 1'b1;
      // first beat of a group overwrites so no previous group's sum leaks in
      for (int l = 0; l < NUM_LANES; l++)
        if (w_hs) acc[l] <= (k_idx == '0 ? '0 : acc[l]) + prod[l];
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic signed [DW-1:0]          w_l;
    logic signed [ACCUM_WIDTH-1:0] sh;
    assign w_l     = w_data[i*DW +: DW];
    assign prod[i] = ACCUM_WIDTH'(x_cur) * ACCUM_WIDTH'(w_l);
    assign sh      = acc[i] >>> sh_cfg;
    assign y_data[i*DW +: DW] = !y_valid ? '0 :
                                sh > YMAX ? YMAX[DW-1:0] :
                                sh < YMIN ? YMIN[DW-1:0] : sh[DW-1:0];
  end
endmodule

// File: tb/tb_mpe_gemv_tile_engine.sv
// tb_mpe_gemv_tile_engine: directed and randomized jobs checked against an arithmetic GEMV reference model
module tb_mpe_gemv_tile_engine;
  localparam int L  = 4;
  localparam int MK = 256;

  logic        clk = 0, rst_n = 0, start = 0;
  logic [8:0]  cfg_k = 0;
  logic [7:0]  cfg_groups = 0;
  logic [4:0]  cfg_shift = 0;
  logic        x_valid = 0, w_valid = 0, y_ready = 0;
  logic [7:0]  x_data = 0;
  logic [31:0] w_data = 0;
  logic        x_ready, w_ready, y_valid, busy, done, err;
  logic [31:0] y_data;

  int n_cmp = 0, n_bad = 0;
  int xa [MK];
  int wa [4][MK][L];

  mpe_gemv_tile_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_k(cfg_k), .cfg_groups(cfg_groups),
    .cfg_shift(cfg_shift), .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .y_valid(y_valid),
    .y_ready(y_ready), .y_data(y_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // plain dot product, wrapped to 32 bits, arithmetic shift, saturate to int8
  function automatic logic [31:0] model(int g, int k, int sh);
    logic [31:0] r;
    longint s;
    int a;
    for (int l = 0; l < L; l++) begin
      s = 0;
      for (int i = 0; i < k; i++) s += longint'(xa[i]) * longint'(wa[g][i][l]);
      a = int'(s) >>> sh;
      a = a > 127 ? 127 : a < -128 ? -128 : a;
      r[l*8 +: 8] = a[7:0];
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(int k, int g, int sh);
    cfg_k = 9'(k);
    cfg_groups = 8'(g);
    cfg_shift = 5'(sh);
    start = 1;
    tick;
    start = 0;
    check("busy_start", busy, 1);
    check("xrdy_start", x_ready, 1);
  endtask

  task automatic send_x(int k, int gap);
    for (int i = 0; i < k; i++) begin
      bit fire = 0;
      int n = 0;
      while (!fire && n < 1000) begin
        x_valid = $urandom_range(99) >= gap;
        x_data = xa[i][7:0];
        fire = x_valid && x_ready;
        tick;
        n++;
      end
      if (!fire) begin
        n_cmp++;
        n_bad++;
        $display("FAIL x_timeout beat=%0d observed=no handshake expected=handshake", i);
      end
    end
    x_valid = 0;
  endtask

  task automatic send_w(int g, int i, int gap);
    bit fire = 0;
    int n = 0;
    for (int l = 0; l < L; l++) w_data[l*8 +: 8] = wa[g][i][l][7:0];
    while (!fire && n < 1000) begin
      w_valid = $urandom_range(99) >= gap;
      fire = w_valid && w_ready;
      tick;
      n++;
    end
    w_valid = 0;
    if (!fire) begin
      n_cmp++;
      n_bad++;
      $display("FAIL w_timeout beat=%0d observed=no handshake expected=handshake", i);
    end
  endtask

  task automatic recv_y(int g, int k, int sh, int stall);
    logic [31:0] hold;
    check("y_lat", y_valid, 1);
    hold = y_data;
    repeat (stall) begin
      y_ready = 0;
      tick;
      check("y_hold", y_data, hold);
      check("y_vld_stall", y_valid, 1);
      check("w_rdy_stall", w_ready, 0);
    end
    check("y_data", y_data, model(g, k, sh));
    y_ready = 1;
    tick;
    y_ready = 0;
  endtask

  task automatic body(int k, int g, int sh, int gap, int stall);
    send_x(k, gap);
    for (int gi = 0; gi < g; gi++) begin
      for (int i = 0; i < k; i++) send_w(gi, i, gap);
      recv_y(gi, k, sh, stall < 0 ? int'($urandom_range(3)) : stall);
      if (gi < g - 1) check("w_rdy_next", w_ready, 1);
      else begin
        check("done", done, 1);
        tick;
        check("done_pulse", done, 0);
        check("busy_end", busy, 0);
      end
    end
  endtask

  task automatic run_job(int k, int g, int sh, int gap, int stall);
    start_job(k, g, sh);
    body(k, g, sh, gap, stall);
  endtask

  task automatic bad_start(int k, int g);
    cfg_k = 9'(k);
    cfg_groups = 8'(g);
    start = 1;
    tick;
    start = 0;
    check("err_set", err, 1);
    check("err_busy", busy, 0);
    check("err_xrdy", x_ready, 0);
    tick;
    check("err_pulse", err, 0);
    check("err_done", done, 0);
    check("err_idle", busy, 0);
  endtask

  task automatic rand_data(int k, int g);
    for (int i = 0; i < k; i++) begin
      xa[i] = int'($urandom_range(255)) - 128;
      for (int gi = 0; gi < g; gi++)
        for (int l = 0; l < L; l++) wa[gi][i][l] = int'($urandom_range(255)) - 128;
    end
  endtask

  initial begin
    #3;
    check("rst_busy", busy, 0);
    check("rst_xrdy", x_ready, 0);
    check("rst_wrdy", w_ready, 0);
    check("rst_yvld", y_valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ydata", y_data, 0);
    @(negedge clk) rst_n = 1;
    tick;

    for (int i = 0; i < 4; i++) begin
      xa[i] = i + 1;
      for (int l = 0; l < L; l++) wa[0][i][l] = 1;
    end
    run_job(4, 1, 0, 0, 0);

    for (int i = 0; i < 4; i++) begin
      xa[i] = 127;
      wa[0][i][0] = 127;
      wa[0][i][1] = -128;
      wa[0][i][2] = 127;
      wa[0][i][3] = -1;
    end
    run_job(4, 1, 0, 0, 0);
    run_job(4, 1, 10, 0, 0);

    rand_data(5, 3);
    run_job(5, 3, 2, 0, 5);

    bad_start(0, 1);
    bad_start(4, 0);
    bad_start(257, 1);

    rand_data(3, 1);
    start_job(3, 1, 1);
    cfg_k = 0;
    start = 1;
    tick;
    check("ld_bad_err", err, 0);
    check("ld_xrdy", x_ready, 1);
    cfg_k = 2;
    cfg_groups = 2;
    tick;
    start = 0;
    check("ld_start_err", err, 0);
    body(3, 1, 1, 0, 0);

    rand_data(4, 1);
    start_job(4, 1, 0);
    send_x(4, 0);
    send_w(0, 0, 0);
    send_w(0, 1, 0);
    #2 rst_n = 0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_wrdy", w_ready, 0);
    check("arst_yvld", y_valid, 0);
    check("arst_ydata", y_data, 0);
    @(negedge clk) rst_n = 1;
    tick;
    xa[0] = 3;
    xa[1] = -2;
    for (int l = 0; l < L; l++) begin
      wa[0][0][l] = 1;
      wa[0][1][l] = 1;
    end
    run_job(2, 1, 0, 0, 0);

    rand_data(MK, 4);
    run_job(MK, 4, 12, 30, -1);
    rand_data(7, 2);
    run_job(7, 2, 0, 40, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
